// File: rtl/ref_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ref_mem_pkg
// Brief    : Shared constants and state encoding for the reference memory loader
// Revision : 1.0 - initial release
// ============================================================================
package ref_mem_pkg;

    localparam int PIXEL     = 8;
    localparam int X         = 32;
    localparam int ADDR_W    = 7;
    localparam int ROWS_W    = 8;
    localparam int NUM_BANKS = X;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int DATA_W    = X * PIXEL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ref_bank_map.sv
`default_nettype none
// ============================================================================
// Module   : ref_bank_map
// Brief    : Maps (row, chunk) of a search window to a one-hot bank and address
// Revision : 1.0 - initial release
// ============================================================================
module ref_bank_map
    import ref_mem_pkg::*;
(
    input  logic [ROWS_W-1:0] i_row,
    input  logic [1:0]        i_chunk,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [2:0]        i_chunks,
    input  logic [BANK_W-1:0] i_ofs,
    output logic [X-1:0]      o_bank_onehot,
    output logic [ADDR_W-1:0] o_addr
);

    logic [BANK_W-1:0]        w_bank;
    logic [ROWS_W-BANK_W-1:0] w_band;
    logic [ADDR_W-1:0]        w_band_ofs;

    // Rows rotate through all banks; every 32 rows a new band of addresses opens.
    assign w_bank        = i_row[BANK_W-1:0] + i_ofs;
    assign w_band        = i_row[ROWS_W-1:BANK_W];
    assign w_band_ofs    = ADDR_W'(w_band) * ADDR_W'(i_chunks);
    assign o_addr        = i_base + w_band_ofs + ADDR_W'(i_chunk);
    assign o_bank_onehot = X'(1) << w_bank;

endmodule
`default_nettype wire

// File: rtl/ref_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : ref_mem_loader
// Brief    : Converts a row-major beat stream into registered 32-bank memory writes
// Revision : 1.0 - initial release
// ============================================================================
module ref_mem_loader
    import ref_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [ROWS_W-1:0]    cfg_rows,
    input  logic [2:0]           cfg_chunks,
    input  logic [BANK_W-1:0]    cfg_bank_ofs,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    output logic [DATA_W-1:0]    ref_input,
    output logic [X-1:0]         Bank_sel,
    output logic [ADDR_W*X-1:0]  write_address_all,
    output logic                 busy,
    output logic                 done
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ROWS_W-1:0]   r_rows;
    logic [2:0]          r_chunks;
    logic [BANK_W-1:0]   r_ofs;
    logic [ROWS_W-1:0]   r_row;
    logic [1:0]          r_chunk;
    logic                r_s_ready;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_data;
    logic [X-1:0]        r_bank_sel;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_accept;
    logic                w_chunk_last;
    logic                w_last;
    logic [X-1:0]        w_bank_onehot;
    logic [ADDR_W-1:0]   w_addr;

    assign w_accept     = s_valid && r_s_ready;
    assign w_chunk_last = ({1'b0, r_chunk} == (r_chunks - 3'd1));
    assign w_last       = w_chunk_last && (r_row == (r_rows - ROWS_W'(1)));

    ref_bank_map u_bank_map (
        .i_row         (r_row),
        .i_chunk       (r_chunk),
        .i_base        (r_base),
        .i_chunks      (r_chunks),
        .i_ofs         (r_ofs),
        .o_bank_onehot (w_bank_onehot),
        .o_addr        (w_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_rows     <= '0;
            r_chunks   <= '0;
            r_ofs      <= '0;
            r_row      <= '0;
            r_chunk    <= '0;
            r_s_ready  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_bank_sel <= '0;
            r_addr     <= '0;
        end else begin
            // Write enable is a single-cycle strobe; data and address hold.
            r_bank_sel <= '0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base   <= cfg_base;
                        r_rows   <= cfg_rows;
                        r_chunks <= cfg_chunks;
                        r_ofs    <= cfg_bank_ofs;
                        r_row    <= '0;
                        r_chunk  <= '0;
                        r_busy   <= 1'b1;
                        if ((cfg_rows != '0) && (cfg_chunks != '0)) begin
                            r_state   <= LOAD;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_data     <= s_data;
                        r_bank_sel <= w_bank_onehot;
                        r_addr     <= w_addr;
                        if (w_last) begin
                            r_state   <= FIN;
                            r_s_ready <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (w_chunk_last) begin
                            r_chunk <= '0;
                            r_row   <= r_row + ROWS_W'(1);
                        end else begin
                            r_chunk <= r_chunk + 2'd1;
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar b = 0; b < X; b++) begin : g_addr
            assign write_address_all[b*ADDR_W +: ADDR_W] = r_addr;
        end
    endgenerate

    assign s_ready   = r_s_ready;
    assign ref_input = r_data;
    assign Bank_sel  = r_bank_sel;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ref_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ref_mem_loader
// Brief    : Scoreboard bench for ref_mem_loader with directed load jobs
// Revision : 1.0 - initial release
// ============================================================================
module tb_ref_mem_loader;
    import ref_mem_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [6:0]   cfg_base = '0;
    logic [7:0]   cfg_rows = '0;
    logic [2:0]   cfg_chunks = '0;
    logic [4:0]   cfg_bank_ofs = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [255:0] s_data = '0;
    logic [255:0] ref_input;
    logic [31:0]  Bank_sel;
    logic [223:0] write_address_all;
    logic         busy;
    logic         done;

    ref_mem_loader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_base          (cfg_base),
        .cfg_rows          (cfg_rows),
        .cfg_chunks        (cfg_chunks),
        .cfg_bank_ofs      (cfg_bank_ofs),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .ref_input         (ref_input),
        .Bank_sel          (Bank_sel),
        .write_address_all (write_address_all),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  sel;
        logic [6:0]   addr;
        bit           last;
    } exp_t;

    exp_t       q[$];
    int         n_vec   = 0;
    int         n_mis   = 0;
    int         n_empty = 0;
    bit         mon_en  = 1'b0;
    logic [7:0] t1_bytes [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every nonzero Bank_sel must match the oldest queued write.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (Bank_sel != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 256'(Bank_sel), 256'(0));
                end else begin
                    e = q.pop_front();
                    chk("bank_sel", 256'(Bank_sel), 256'(e.sel));
                    chk("ref_input", ref_input, e.data);
                    chk("write_addr", 256'(write_address_all), 256'({32{e.addr}}));
                    chk("done_with_write", 256'(done), 256'(e.last));
                end
            end else if (done) begin
                if (n_empty == 0) chk("unexpected_done", 256'(done), 256'(0));
                else n_empty--;
            end
        end
    end

    task automatic run_job(input logic [6:0] base, input logic [7:0] rows, input logic [2:0] chunks,
                           input logic [4:0] ofs, input bit gaps, input bit t1);
        int         total, sent, k, r, c;
        bit         v;
        logic [3:0] pat;
        logic [31:0] w;
        exp_t       e;
        pat   = 4'b1001;
        total = int'(rows) * int'(chunks);
        chk("idle_s_ready", 256'(s_ready), 256'(0));
        start        = 1'b1;
        cfg_base     = base;
        cfg_rows     = rows;
        cfg_chunks   = chunks;
        cfg_bank_ofs = ofs;
        if (total == 0) n_empty++;
        @(posedge clk); #1;
        start = 1'b0;
        if (total == 0) begin
            chk("empty_done", 256'(done), 256'(1));
            chk("empty_s_ready", 256'(s_ready), 256'(0));
            chk("empty_busy", 256'(busy), 256'(1));
            @(posedge clk); #1;
            chk("empty_done_clear", 256'(done), 256'(0));
            chk("empty_busy_clear", 256'(busy), 256'(0));
            return;
        end
        chk("load_s_ready", 256'(s_ready), 256'(1));
        chk("load_busy", 256'(busy), 256'(1));
        sent = 0; k = 0; r = 0; c = 0;
        while (sent < total) begin
            v = gaps ? pat[k % 4] : 1'b1;
            s_valid = v;
            if (v) begin
                if (t1) begin
                    s_data = {32{t1_bytes[sent]}};
                end else begin
                    w = 32'hA500_0000 + 32'(int'(base) << 16) + 32'(sent);
                    s_data = {8{w}};
                end
                e.data = s_data;
                e.sel  = 32'(1) << ((r + int'(ofs)) % 32);
                e.addr = 7'((int'(base) + (r / 32) * int'(chunks) + c) % 128);
                e.last = (sent == total - 1);
                q.push_back(e);
                chk("s_ready_during_load", 256'(s_ready), 256'(1));
                sent++;
                c++;
                if (c == int'(chunks)) begin
                    c = 0;
                    r++;
                end
            end
            @(posedge clk); #1;
            if (!v) chk("gap_no_write", 256'(Bank_sel), 256'(0));
            k++;
        end
        s_valid = 1'b0;
        chk("fin_done", 256'(done), 256'(1));
        chk("fin_busy", 256'(busy), 256'(1));
        // A start during FIN must be dropped.
        start      = 1'b1;
        cfg_rows   = 8'd1;
        cfg_chunks = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_busy", 256'(busy), 256'(0));
        chk("idle_done", 256'(done), 256'(0));
        chk("idle_s_ready_after", 256'(s_ready), 256'(0));
    endtask

    initial begin
        exp_t        e;
        logic [31:0] w;
        t1_bytes[0] = 8'h55;
        t1_bytes[1] = 8'h33;
        t1_bytes[2] = 8'h0F;
        t1_bytes[3] = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("rst_bank_sel", 256'(Bank_sel), 256'(0));
        chk("rst_ref_input", ref_input, 256'(0));
        chk("rst_addr", 256'(write_address_all), 256'(0));
        chk("rst_s_ready", 256'(s_ready), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(7'd0,   8'd4,  3'd1, 5'd0,  1'b0, 1'b1);
        run_job(7'd5,   8'd40, 3'd2, 5'd30, 1'b0, 1'b0);
        run_job(7'd9,   8'd3,  3'd2, 5'd7,  1'b1, 1'b0);
        run_job(7'd127, 8'd1,  3'd3, 5'd0,  1'b0, 1'b0);
        run_job(7'd0,   8'd0,  3'd2, 5'd0,  1'b0, 1'b0);
        run_job(7'd3,   8'd5,  3'd0, 5'd0,  1'b0, 1'b0);

        // Mid-job reset after three writes.
        start        = 1'b1;
        cfg_base     = 7'd10;
        cfg_rows     = 8'd8;
        cfg_chunks   = 3'd1;
        cfg_bank_ofs = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            w       = 32'h5EED_0000 + 32'(i);
            s_data  = {8{w}};
            e.data  = s_data;
            e.sel   = 32'(1) << (i + 3);
            e.addr  = 7'd10;
            e.last  = 1'b0;
            q.push_back(e);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        chk("midrst_bank_sel", 256'(Bank_sel), 256'(0));
        chk("midrst_ref_input", ref_input, 256'(0));
        chk("midrst_addr", 256'(write_address_all), 256'(0));
        chk("midrst_s_ready", 256'(s_ready), 256'(0));
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_done", 256'(done), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        run_job(7'd0, 8'd2, 3'd1, 5'd0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 256'(q.size()), 256'(0));
        chk("empty_done_seen", 256'(n_empty), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire
